button_debouncer: RTL and testbench

//  Conditions the raw low-active pushbutton (btnx) before it reaches the blink/counter logic.

---
 rtl/button_debouncer_if.sv | 34 +++
 rtl/button_debouncer.sv | 207 ++++++++++++++++++++
 tb/tb_button_debouncer.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/button_debouncer_if.sv
// -----------------------------------------------------------------------------
// button_debouncer_if
//   Signal bundle between the raw board button pin and its debouncer.
//   btnx          raw button pin, low active (pressed = 0), asynchronous
//   btn_level     debounced level, 1 = pressed
//   press_tick    one clk pulse when a press is accepted
//   release_tick  one clk pulse when a release is accepted
//   long_tick     one clk pulse per press held long enough (0 when disabled)
//   Modports: master = side that owns the pin and consumes the events,
//             slave  = the debouncer itself.
// -----------------------------------------------------------------------------
interface button_debouncer_if;
    logic btnx;
    logic btn_level;
    logic press_tick;
    logic release_tick;
    logic long_tick;

    modport master (
        output btnx,
        input  btn_level,
        input  press_tick,
        input  release_tick,
        input  long_tick
    );

    modport slave (
        input  btnx,
        output btn_level,
        output press_tick,
        output release_tick,
        output long_tick
    );
endinterface

// File: rtl/button_debouncer.sv
// -----------------------------------------------------------------------------
// button_debouncer
//   Conditions the raw low-active pushbutton before the blink/counter logic:
//   synchronises btnx into the clk domain, filters contact bounce with a
//   stability counter and emits a clean level plus one-cycle press/release
//   ticks usable as reset or step strobes.
//
// Parameters
//   InputClock      input clock in MHz (documentation only)
//   DebounceCycles  clk cycles the input must be stable to accept a change (>= 2)
//   SyncStages      synchroniser flip-flops on btnx (>= 2)
//   LongCycles      clk cycles held to flag a long press (LONG_PRESS_EN only)
//
// Ports
//   clk   system clock
//   rst   synchronous reset, active high
//   pins  button_debouncer_if.slave: btnx in; btn_level, press_tick,
//         release_tick, long_tick out (all outputs registered)
//
// Build option
//   LONG_PRESS_EN  when defined, adds the long-press counter driving long_tick;
//                  otherwise long_tick is tied to 0.
// -----------------------------------------------------------------------------
module button_debouncer #(
    parameter real InputClock     = 24.0,
    parameter int  DebounceCycles = 240000,
    parameter int  SyncStages     = 2,
    parameter int  LongCycles     = 24000000
) (
    input  logic              clk,
    input  logic              rst,
    button_debouncer_if.slave pins
);

    // Number of bits needed to hold 'value' (at least 1).
    function automatic int bits_for(input int value);
        int w;
        w = 32'sd1;
        for (int i = 1; i < 31; i++) begin
            if ((value >> i) != 32'sd0) begin
                w = i + 32'sd1;
            end
        end
        return w;
    endfunction

    localparam int            CW      = bits_for(DebounceCycles - 32'sd1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DebounceCycles - 32'sd1);

    if (DebounceCycles < 32'sd2 || SyncStages < 32'sd2 ||
        LongCycles < 32'sd2 || InputClock <= 0.0) begin : g_bad_params
        $error("button_debouncer: invalid parameter values");
    end

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_t;

    logic [SyncStages-1:0] sync_r;
    logic                  sp_s;
    state_t                state_r, state_nx_s;
    logic [CW-1:0]         cnt_r, cnt_nx_s;
    logic                  level_r, level_nx_s;
    logic                  press_r, press_nx_s;
    logic                  release_r, release_nx_s;

    // Synchroniser chain; resets to the released (high) pin level.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_r <= '1;
        end else begin
            sync_r <= {sync_r[SyncStages-2:0], pins.btnx};
        end
    end

    // Pressed flag seen by the filter (pin is low active).
    assign sp_s = ~sync_r[SyncStages-1];

    // FSM, stability counter and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= IDLE;
            cnt_r     <= '0;
            level_r   <= 1'b0;
            press_r   <= 1'b0;
            release_r <= 1'b0;
        end else begin
            state_r   <= state_nx_s;
            cnt_r     <= cnt_nx_s;
            level_r   <= level_nx_s;
            press_r   <= press_nx_s;
            release_r <= release_nx_s;
        end
    end

    // Next state: any disagreement restarts the wait, so cnt never wraps.
    always_comb begin
        state_nx_s   = state_r;
        cnt_nx_s     = cnt_r;
        level_nx_s   = level_r;
        press_nx_s   = 1'b0;
        release_nx_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (sp_s) begin
                    state_nx_s = PRESS_WAIT;
                    cnt_nx_s   = '0;
                end else begin
                    cnt_nx_s   = '0;
                end
            end
            PRESS_WAIT: begin
                if (!sp_s) begin
                    state_nx_s = IDLE;
                    cnt_nx_s   = '0;
                end else if (cnt_r == CNT_MAX) begin
                    state_nx_s = PRESSED;
                    cnt_nx_s   = '0;
                    level_nx_s = 1'b1;
                    press_nx_s = 1'b1;
                end else begin
                    cnt_nx_s   = cnt_r + CW'(1'b1);
                end
            end
            PRESSED: begin
                if (!sp_s) begin
                    state_nx_s = RELEASE_WAIT;
                    cnt_nx_s   = '0;
                end else begin
                    cnt_nx_s   = '0;
                end
            end
            RELEASE_WAIT: begin
                if (sp_s) begin
                    state_nx_s = PRESSED;
                    cnt_nx_s   = '0;
                end else if (cnt_r == CNT_MAX) begin
                    state_nx_s   = IDLE;
                    cnt_nx_s     = '0;
                    level_nx_s   = 1'b0;
                    release_nx_s = 1'b1;
                end else begin
                    cnt_nx_s     = cnt_r + CW'(1'b1);
                end
            end
            default: begin
                state_nx_s = IDLE;
                cnt_nx_s   = '0;
                level_nx_s = 1'b0;
            end
        endcase
    end

    assign pins.btn_level    = level_r;
    assign pins.press_tick   = press_r;
    assign pins.release_tick = release_r;

`ifdef LONG_PRESS_EN
    localparam int            LW       = bits_for(LongCycles - 32'sd1);
    localparam logic [LW-1:0] LCNT_MAX = LW'(LongCycles - 32'sd1);

    logic [LW-1:0] lcnt_r, lcnt_nx_s;
    logic          ldone_r, ldone_nx_s;
    logic          long_r, long_nx_s;

    // Long-press counter and its once-per-press tick.
    always_ff @(posedge clk) begin
        if (rst) begin
            lcnt_r  <= '0;
            ldone_r <= 1'b0;
            long_r  <= 1'b0;
        end else begin
            lcnt_r  <= lcnt_nx_s;
            ldone_r <= ldone_nx_s;
            long_r  <= long_nx_s;
        end
    end

    // Counter saturates; ldone keeps the tick to one per accepted press.
    always_comb begin
        lcnt_nx_s  = lcnt_r;
        ldone_nx_s = ldone_r;
        long_nx_s  = 1'b0;
        if (state_r == PRESS_WAIT && state_nx_s == PRESSED) begin
            lcnt_nx_s  = '0;
            ldone_nx_s = 1'b0;
        end else if (state_r == PRESSED || state_r == RELEASE_WAIT) begin
            if (lcnt_r == LCNT_MAX) begin
                long_nx_s  = ~ldone_r;
                ldone_nx_s = 1'b1;
            end else begin
                lcnt_nx_s  = lcnt_r + LW'(1'b1);
            end
        end else begin
            lcnt_nx_s  = lcnt_r;
        end
    end

    assign pins.long_tick = long_r;
`else
    assign pins.long_tick = 1'b0;
`endif

endmodule

// File: tb/tb_button_debouncer.sv
// -----------------------------------------------------------------------------
// tb_button_debouncer
//   Scoreboard bench: a reference model steps on every clock edge and queues
//   the expected {btn_level, press_tick, release_tick, long_tick}; the checker
//   pops one entry per cycle on the falling edge and compares. Directed
//   scenarios also compare tick counts against fixed expectations.
// -----------------------------------------------------------------------------
module tb_button_debouncer;

    localparam int D = 4;
    localparam int L = 16;
`ifdef LONG_PRESS_EN
    localparam bit LONG_ON = 1'b1;
`else
    localparam bit LONG_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;

    button_debouncer_if bif ();

    button_debouncer #(
        .InputClock     (24.0),
        .DebounceCycles (D),
        .SyncStages     (2),
        .LongCycles     (L)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .pins (bif)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;
    int n_press = 0, n_release = 0, n_long = 0;
    int s_press = 0, s_release = 0, s_long = 0;
    logic [3:0] exp_q[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: two-stage pipeline of the pin, then a run-length filter.
    logic m_s1 = 1'b1, m_s2 = 1'b1, m_lvl = 1'b0, m_ldone = 1'b0;
    int   m_run = 0, m_lcnt = 0;

    always @(posedge clk) begin
        logic sp, pr, rl, lg, old;
        pr = 1'b0; rl = 1'b0; lg = 1'b0;
        if (rst) begin
            m_s1 = 1'b1; m_s2 = 1'b1; m_run = 0; m_lvl = 1'b0;
            m_lcnt = 0; m_ldone = 1'b0;
        end else begin
            sp   = ~m_s2;
            m_s2 = m_s1;
            m_s1 = bif.btnx;
            old  = m_lvl;
            if (LONG_ON && old) begin
                lg = (m_lcnt == L - 1) && !m_ldone;
                if (lg) m_ldone = 1'b1;
                if (m_lcnt < L - 1) m_lcnt++;
            end
            if (sp != m_lvl) begin
                m_run++;
                if (m_run == D + 1) begin
                    m_lvl = sp; pr = sp; rl = ~sp; m_run = 0;
                    if (sp) begin m_lcnt = 0; m_ldone = 1'b0; end
                end
            end else begin
                m_run = 0;
            end
        end
        exp_q.push_back({m_lvl, pr, rl, lg});
    end

    // Checker: one expected vector per cycle, plus tick tallies.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [3:0] e;
            e = exp_q.pop_front();
            check_eq("outs", {28'd0, bif.btn_level, bif.press_tick, bif.release_tick, bif.long_tick},
                     {28'd0, e});
        end
        if (bif.press_tick)   n_press++;
        if (bif.release_tick) n_release++;
        if (bif.long_tick)    n_long++;
    end

    task automatic step(input logic b, input int n);
        for (int k = 0; k < n; k++) begin
            bif.btnx = b;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic expect_ticks(input string tag, input int p, input int r, input int l);
        @(negedge clk);
        #1;
        check_eq({tag, "_press"},   n_press - s_press,     p);
        check_eq({tag, "_release"}, n_release - s_release, r);
        check_eq({tag, "_long"},    n_long - s_long,       l);
        s_press = n_press; s_release = n_release; s_long = n_long;
    endtask

    initial begin
        bif.btnx = 1'b0;
        rst = 1'b1;
        step(1'b0, 3);
        expect_ticks("reset", 0, 0, 0);
        rst = 1'b0;
        step(1'b0, 12);
        expect_ticks("after_reset", 1, 0, 0);
        step(1'b1, 12);
        expect_ticks("release", 0, 1, 0);

        // clean press held 20 cycles, then release
        step(1'b0, 20);
        step(1'b1, 12);
        expect_ticks("clean", 1, 1, LONG_ON ? 1 : 0);

        // bounce on press, then bounce on release
        step(1'b0, 2); step(1'b1, 1); step(1'b0, 2); step(1'b1, 1);
        step(1'b0, 8);
        step(1'b1, 1); step(1'b0, 1); step(1'b1, 2); step(1'b0, 1);
        step(1'b1, 12);
        expect_ticks("bounce", 1, 1, 0);

        // short glitches never reach the level
        for (int k = 0; k < 6; k++) begin
            step(1'b0, 1 + (k % 4));
            step(1'b1, 1);
        end
        step(1'b1, 8);
        expect_ticks("glitch", 0, 0, 0);

        // long press
        step(1'b0, 40);
        step(1'b1, 12);
        expect_ticks("long", 1, 1, LONG_ON ? 1 : 0);

        // reset while waiting for a press to settle
        step(1'b0, 5);
        rst = 1'b1;
        step(1'b0, 1);
        rst = 1'b0;
        expect_ticks("mid_reset", 0, 0, 0);
        step(1'b0, 12);
        expect_ticks("repress", 1, 0, 0);
        step(1'b1, 12);
        expect_ticks("rerelease", 0, 1, 0);

        // random runs, checked by the scoreboard only
        for (int k = 0; k < 60; k++) begin
            step(1'($urandom_range(0, 1)), $urandom_range(1, 9));
        end
        step(1'b1, 30);

        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
